// File: rtl/basket_pkg.sv
// ---------------------------------------------------------------------------
// basket_pkg
//   Shared definitions for the basketball round controller:
//     - state_e          : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//     - OFFSET_DEF       : default bias added to the remaining seconds on reg_C
//     - LED_BAR_MAX_SEC  : longest round the 8-LED bar can show
//     - sat_inc8         : 8-bit increment that sticks at 255
//     - floor_dec8       : 8-bit decrement that sticks at 0
// ---------------------------------------------------------------------------
package basket_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned OFFSET_DEF      = 16;
  localparam int unsigned LED_BAR_MAX_SEC = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] floor_dec8(input logic [7:0] v);
    return (v == 8'd0) ? v : v - 8'd1;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// ---------------------------------------------------------------------------
// sec_tick
//   Prescaler that counts 0..TICK_DIV-1 while enabled and wraps; the cycle in
//   which it sits on the last count (and is enabled) raises tick for exactly
//   one cycle. With en low the count is frozen; clr forces the count to 0.
//
//   Ports:
//     clk   in  1  system clock, rising edge
//     rst   in  1  synchronous active-high reset (count -> 0)
//     en    in  1  advance the count this cycle
//     clr   in  1  clear the count (overrides en)
//     tick  out 1  one-cycle pulse on each wrap
// ---------------------------------------------------------------------------
module sec_tick #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  // A clear in the same cycle as a wrap suppresses the tick: the owner is
  // restarting the timebase, so the stale second must not be reported.
  assign tick = en && wrap && !clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/basket_round_ctrl.sv
// ---------------------------------------------------------------------------
// basket_round_ctrl
//   Round timer and score keeper for a basketball arcade game. A start pulse
//   loads ROUND_SEC seconds and runs the clock down one second per prescaler
//   tick; pause toggles RUN/PAUSE; shots score only while running. When the
//   last second expires the FSM enters DONE and buzzer pulses for one cycle.
//
//   Ports:
//     clk     in  1  system clock, rising edge
//     rst     in  1  synchronous active-high reset, overrides all inputs
//     start   in  1  pulse: (re)start a round from any state
//     pause   in  1  pulse: toggle RUN <-> PAUSE
//     shot    in  1  pulse: basket scored (debounced upstream)
//     reg_C   out 8  OFFSET + remaining seconds, registered
//     score   out 8  baskets in the current round, saturates at 255
//     state   out 2  FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//     buzzer  out 1  one-cycle pulse when the round expires
// ---------------------------------------------------------------------------
module basket_round_ctrl
  import basket_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned ROUND_SEC = LED_BAR_MAX_SEC,
  parameter int unsigned OFFSET    = OFFSET_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       shot,
  output logic [7:0] reg_C,
  output logic [7:0] score,
  output logic [1:0] state,
  output logic       buzzer
);

  localparam logic [7:0] ROUND_LD = 8'(ROUND_SEC);
  localparam logic [7:0] OFFS     = 8'(OFFSET);

  state_e     state_q;
  logic [7:0] remaining_q;
  logic [7:0] reg_c_q;
  logic [7:0] score_q;
  logic       buzzer_q;

  logic [7:0] score_d;
  logic [7:0] remaining_d;
  logic       tick;
  logic       tick_en;
  logic       tick_clr;
  logic       final_tick;

  // Prescaler only advances while running; it is parked at 0 outside a
  // round and restarted by every start so each round gets full seconds.
  assign tick_en  = (state_q == ST_RUN);
  assign tick_clr = start || (state_q == ST_IDLE) || (state_q == ST_DONE);

  sec_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign score_d     = sat_inc8(score_q);
  assign remaining_d = floor_dec8(remaining_q);

  // <= 1 rather than == 1 so a zero count can never be decremented past 0.
  assign final_tick  = tick && (remaining_q <= 8'd1);

  always_ff @(posedge clk) begin
    buzzer_q <= 1'b0;
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      reg_c_q     <= OFFS;
      score_q     <= 8'd0;
    end else if (start) begin
      state_q     <= ST_RUN;
      remaining_q <= ROUND_LD;
      reg_c_q     <= OFFS + ROUND_LD;
      score_q     <= 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Shots are counted even on the expiring tick.
          if (shot) begin
            score_q <= score_d;
          end
          if (final_tick) begin
            // Expiry beats a coincident pause.
            state_q     <= ST_DONE;
            remaining_q <= 8'd0;
            reg_c_q     <= OFFS;
            buzzer_q    <= 1'b1;
          end else begin
            if (tick) begin
              remaining_q <= remaining_d;
              reg_c_q     <= OFFS + remaining_d;
            end
            // A pause on an ordinary tick still takes that second off.
            if (pause) begin
              state_q <= ST_PAUSE;
            end
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          // IDLE and DONE hold everything until start or rst.
        end
      endcase
    end
  end

  assign reg_C  = reg_c_q;
  assign score  = score_q;
  assign state  = state_q;
  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_basket_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_basket_round_ctrl
//   Directed bench for basket_round_ctrl with TICK_DIV=4, ROUND_SEC=8,
//   OFFSET=16. Inputs change 1 time unit after a rising edge and outputs are
//   checked at that same point, so every check sees the result of the edge
//   just taken. Edge En is the n-th edge after the start edge E0.
// ---------------------------------------------------------------------------
module tb_basket_round_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned RS = 8;
  localparam int unsigned OF = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       shot;
  logic [7:0] reg_C;
  logic [7:0] score;
  logic [1:0] state;
  logic       buzzer;

  int checks    = 0;
  int failures  = 0;
  int buzz_cnt  = 0;
  int b0        = 0;

  always #5 clk = ~clk;

  basket_round_ctrl #(
    .TICK_DIV  (TD),
    .ROUND_SEC (RS),
    .OFFSET    (OF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .shot   (shot),
    .reg_C  (reg_C),
    .score  (score),
    .state  (state),
    .buzzer (buzzer)
  );

  // Counts buzzer cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (buzzer === 1'b1) buzz_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic sh);
    start = s;
    pause = p;
    shot  = sh;
    step();
    start = 1'b0;
    pause = 1'b0;
    shot  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    shot  = 1'b0;
    step();
    step();
    check("rst_state", state, 0);
    check("rst_regc", reg_C, 16);
    check("rst_score", score, 0);
    check("rst_buzzer", buzzer, 0);

    // rst overrides start.
    drive(1'b1, 1'b1, 1'b1);
    check("rst_over_start_state", state, 0);
    check("rst_over_start_regc", reg_C, 16);
    rst = 1'b0;

    // Idle 20 cycles, nothing moves.
    b0 = buzz_cnt;
    idle(20);
    check("idle_state", state, 0);
    check("idle_regc", reg_C, 16);
    check("idle_score", score, 0);
    check("idle_no_buzz", buzz_cnt - b0, 0);

    // Plain round: one second every 4 cycles, DONE at E32.
    b0 = buzz_cnt;
    drive(1'b1, 1'b0, 1'b0);
    check("run_state_e0", state, 1);
    check("run_regc_e0", reg_C, 24);
    for (int n = 1; n <= 32; n++) begin
      step();
      check("run_regc", reg_C, 24 - n / 4);
      check("run_state", state, (n < 32) ? 1 : 3);
    end
    check("run_buzz_e32", buzzer, 1);
    step();
    check("run_buzz_e33", buzzer, 0);
    check("run_done_state", state, 3);
    idle(10);
    check("done_regc_hold", reg_C, 16);
    check("done_state_hold", state, 3);
    check("run_one_buzz", buzz_cnt - b0, 1);

    // Shots: 3 in RUN, 2 in PAUSE, 1 in DONE.
    drive(1'b1, 1'b0, 1'b0);         // E0
    drive(1'b0, 1'b0, 1'b1);         // E1
    drive(1'b0, 1'b0, 1'b0);         // E2
    drive(1'b0, 1'b0, 1'b1);         // E3
    drive(1'b0, 1'b0, 1'b0);         // E4 (first tick lands here)
    drive(1'b0, 1'b0, 1'b1);         // E5
    check("shot_run_score", score, 3);
    drive(1'b0, 1'b1, 1'b0);         // E6 -> PAUSE
    check("shot_pause_state", state, 2);
    drive(1'b0, 1'b0, 1'b1);         // E7
    drive(1'b0, 1'b0, 1'b1);         // E8
    check("shot_pause_ignored", score, 3);
    check("shot_pause_regc", reg_C, 23);
    drive(1'b0, 1'b1, 1'b0);         // E9 -> RUN
    check("shot_resume_state", state, 1);
    idle(26);                        // E35
    check("shot_done_state", state, 3);
    check("shot_done_buzz", buzzer, 1);
    drive(1'b0, 1'b0, 1'b1);
    check("shot_done_ignored", score, 3);

    // Pause with frozen prescaler value 2 for 10 cycles; round takes 42.
    drive(1'b1, 1'b0, 1'b0);         // E0
    step();                          // E1
    drive(1'b0, 1'b1, 1'b0);         // E2 -> PAUSE
    check("frz_state", state, 2);
    for (int n = 3; n <= 11; n++) begin
      step();
      check("frz_regc", reg_C, 24);
    end
    check("frz_state_end", state, 2);
    drive(1'b0, 1'b1, 1'b0);         // E12 -> RUN
    check("frz_resume_state", state, 1);
    step();                          // E13
    check("frz_no_tick_yet", reg_C, 24);
    step();                          // E14
    check("frz_tick_after_2", reg_C, 23);
    idle(27);                        // E41
    check("frz_e41_state", state, 1);
    check("frz_e41_regc", reg_C, 17);
    step();                          // E42
    check("frz_e42_state", state, 3);
    check("frz_e42_buzz", buzzer, 1);

    // Pause on a non-final tick: decrement then PAUSE.
    drive(1'b1, 1'b0, 1'b0);         // E0
    idle(3);                         // E3, tick cycle follows
    drive(1'b0, 1'b1, 1'b0);         // E4
    check("ptick_state", state, 2);
    check("ptick_regc", reg_C, 23);

    // Reach DONE with score 5, then start+pause+shot together.
    drive(1'b1, 1'b0, 1'b0);         // E0
    repeat (5) drive(1'b0, 1'b0, 1'b1);  // E1..E5
    idle(27);                        // E32
    check("s5_state", state, 3);
    check("s5_score", score, 5);
    drive(1'b1, 1'b1, 1'b1);         // new E0
    check("prio_state", state, 1);
    check("prio_score", score, 0);
    check("prio_regc", reg_C, 24);

    // Shot and pause on the final tick.
    b0 = buzz_cnt;
    idle(31);                        // E31
    check("fin_e31_state", state, 1);
    check("fin_e31_regc", reg_C, 17);
    drive(1'b0, 1'b1, 1'b1);         // E32
    check("fin_state", state, 3);
    check("fin_score", score, 1);
    check("fin_buzz", buzzer, 1);
    check("fin_regc", reg_C, 16);
    step();
    check("fin_stays_done", state, 3);
    check("fin_buzz_once", buzz_cnt - b0, 1);

    // Second run aborted by rst: no buzzer.
    b0 = buzz_cnt;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle(4);
    check("abort_pre_score", score, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", state, 0);
    check("abort_regc", reg_C, 16);
    check("abort_score", score, 0);
    check("abort_buzzer", buzzer, 0);
    idle(40);
    check("abort_idle_state", state, 0);
    check("abort_no_buzz", buzz_cnt - b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
